// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32-style ALU core: FETCH/DECODE/EXEC/WB FSM over a handshaked imem port.
// Define MULTI_CYCLE_MUL_EN to add an iterative shift-add MUL instruction (extra MUL state).
module multi_cycle_cpu #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NREG     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_instr_i,
   output logic            busy_o,
   output logic            retire_o,
   output logic [XLEN-1:0] retire_pc_o,
   input  logic [4:0]      dbg_addr_i,
   output logic [XLEN-1:0] dbg_data_o
);
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned SW = $clog2(XLEN);

   localparam logic [6:0] OpReg = 7'b0110011;
   localparam logic [6:0] OpImm = 7'b0010011;

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StWb
`ifdef MULTI_CYCLE_MUL_EN
      , StMul
`endif
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q, result_q;
   logic [31:0]     instr_q;
   logic            wr_en_q;
   logic [XLEN-1:0] rf_q [NREG];

   logic [6:0]      op, f7;
   logic [2:0]      f3;
   logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx, dbg_idx;
   logic [XLEN-1:0] alu_res;
   logic            alu_ok;

`ifdef MULTI_CYCLE_MUL_EN
   logic            is_mul;
   logic [XLEN-1:0] mcand_q, mplier_q;
   logic [SW-1:0]   mcnt_q;
`endif

   assign op      = instr_q[6:0];
   assign f3      = instr_q[14:12];
   assign f7      = instr_q[31:25];
   assign rd_idx  = instr_q[7 +: RW];
   assign rs1_idx = instr_q[15 +: RW];
   assign rs2_idx = instr_q[20 +: RW];
   assign dbg_idx = dbg_addr_i[RW-1:0];

   // rf_q[0] is never written, so it always reads as zero.
   assign dbg_data_o  = rf_q[dbg_idx];
   assign imem_req_o  = (state_q == StFetch);
   assign imem_addr_o = imem_req_o ? pc_q : '0;
   assign busy_o      = (state_q != StIdle);
   assign retire_o    = (state_q == StWb);
   assign retire_pc_o = retire_o ? pc_q : '0;

   always_comb begin
      alu_res = '0;
      alu_ok  = 1'b0;
`ifdef MULTI_CYCLE_MUL_EN
      is_mul  = 1'b0;
`endif
      if (op == OpReg && f7 == 7'b0000000) begin
         alu_ok = 1'b1;
         case (f3)
            3'b000:  alu_res = rs1_q + rs2_q;
            3'b111:  alu_res = rs1_q & rs2_q;
            3'b110:  alu_res = rs1_q | rs2_q;
            3'b100:  alu_res = rs1_q ^ rs2_q;
            3'b001:  alu_res = rs1_q << rs2_q[SW-1:0];
            default: alu_ok  = 1'b0;
         endcase
      end else if (op == OpReg && f7 == 7'b0100000 && f3 == 3'b000) begin
         alu_ok  = 1'b1;
         alu_res = rs1_q - rs2_q;
      end else if (op == OpImm && f3 == 3'b000) begin
         alu_ok  = 1'b1;
         alu_res = rs1_q + imm_q;
      end
`ifdef MULTI_CYCLE_MUL_EN
      else if (op == OpReg && f7 == 7'b0000001 && f3 == 3'b000) begin
         is_mul = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start_i) state_d = StFetch;
         StFetch:  if (imem_ack_i) state_d = StDecode;
         StDecode: state_d = StExec;
         StExec: begin
            state_d = StWb;
`ifdef MULTI_CYCLE_MUL_EN
            if (is_mul) state_d = StMul;
`endif
         end
`ifdef MULTI_CYCLE_MUL_EN
         StMul:    if (mcnt_q == SW'(XLEN - 1)) state_d = StWb;
`endif
         StWb:     state_d = start_i ? StFetch : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_q     <= PC_RESET;
         instr_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         result_q <= '0;
         wr_en_q  <= 1'b0;
`ifdef MULTI_CYCLE_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         mcnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            StFetch: if (imem_ack_i) instr_q <= imem_instr_i;
            StDecode: begin
               rs1_q <= rf_q[rs1_idx];
               rs2_q <= rf_q[rs2_idx];
               imm_q <= {{(XLEN - 12){instr_q[31]}}, instr_q[31:20]};
            end
            StExec: begin
               result_q <= alu_res;
               wr_en_q  <= alu_ok && (rd_idx != '0);
`ifdef MULTI_CYCLE_MUL_EN
               if (is_mul) begin
                  result_q <= '0;
                  wr_en_q  <= (rd_idx != '0);
                  mcand_q  <= rs1_q;
                  mplier_q <= rs2_q;
                  mcnt_q   <= '0;
               end
`endif
            end
`ifdef MULTI_CYCLE_MUL_EN
            // One shift-add step per cycle; result_q accumulates the low XLEN product bits.
            StMul: begin
               result_q <= result_q + (mplier_q[0] ? mcand_q : '0);
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               mcnt_q   <= mcnt_q + 1'b1;
            end
`endif
            StWb:    pc_q <= pc_q + XLEN'(4);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      end else if (state_q == StWb && wr_en_q) begin
         rf_q[rd_idx] <= result_q;
      end
   end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Randomized self-checking bench for multi_cycle_cpu against an instruction-level reference model.
// Honours MULTI_CYCLE_MUL_EN the same way as the design.
module tb_multi_cycle_cpu;
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam logic [XLEN-1:0] PC_RESET = '0;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            start_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ack_i;
   logic [31:0]     imem_instr_i;
   logic            busy_o;
   logic            retire_o;
   logic [XLEN-1:0] retire_pc_o;
   logic [4:0]      dbg_addr_i;
   logic [XLEN-1:0] dbg_data_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [XLEN-1:0] mreg [32];
   logic [XLEN-1:0] mpc;

   multi_cycle_cpu #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .PC_RESET (PC_RESET)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_instr_i (imem_instr_i),
      .busy_o       (busy_o),
      .retire_o     (retire_o),
      .retire_pc_o  (retire_pc_o),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_data_o   (dbg_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] mread(input int idx);
      int a;
      a = idx % NREG;
      return (a == 0) ? '0 : mreg[a];
   endfunction

   // Architectural effect of one instruction, computed straight from the ISA rules.
   task automatic model_exec(input logic [31:0] ins, output bit mul);
      logic [6:0]      op, f7;
      logic [2:0]      f3;
      logic [11:0]     i12;
      logic [XLEN-1:0] a, b, imm, val;
      bit              wr;
      op  = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      i12 = ins[31:20];
      imm = XLEN'($signed(i12));
      a   = mread(int'(ins[19:15]));
      b   = mread(int'(ins[24:20]));
      wr  = 1'b1;
      mul = 1'b0;
      val = '0;
      if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0)      val = a + b;
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) val = a - b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) val = a & b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) val = a | b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) val = a ^ b;
      else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) val = a << (b % XLEN);
      else if (op == 7'h13 && f3 == 3'd0)                val = a + imm;
`ifdef MULTI_CYCLE_MUL_EN
      else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin
         val = a * b;
         mul = 1'b1;
      end
`endif
      else wr = 1'b0;
      if (wr && (int'(ins[11:7]) % NREG) != 0) mreg[int'(ins[11:7]) % NREG] = val;
      mpc = mpc + XLEN'(4);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] ins;
      rd  = 5'($urandom);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 10))
         0:       ins = {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
         1:       ins = {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
         2:       ins = {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
         3:       ins = {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
         4:       ins = {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
         5:       ins = {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
         6, 7, 8: ins = {12'($urandom), rs1, 3'd0, rd, 7'h13};
         9:       ins = {7'h01, rs2, rs1, 3'd0, rd, 7'h33};
         default: begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[6:0] = 7'h23;
            else begin
               ins[6:0]   = 7'h13;
               ins[14:12] = 3'd5;
            end
         end
      endcase
      return ins;
   endfunction

   // Serve one fetch after dly wait cycles, follow it to retire and check the architectural result.
   task automatic run_instr(input logic [31:0] ins, input int dly, input bit keep_start);
      int unsigned n;
      int unsigned exp_lat;
      bit          mul;
      logic [4:0]  ra;
      n = 0;
      while (!imem_req_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      check("req_seen", imem_req_o, 1);
      check("fetch_addr", imem_addr_o, mpc);
      check("busy_fetch", busy_o, 1);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk_i);
         check("req_hold", imem_req_o, 1);
         check("addr_hold", imem_addr_o, mpc);
      end
      imem_ack_i   = 1'b1;
      imem_instr_i = ins;
      start_i      = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      n = 1;
      while (!retire_o && n < 3 + XLEN + 5) begin
         // Acks outside FETCH must be ignored.
         imem_ack_i   = 1'($urandom_range(0, 1));
         imem_instr_i = $urandom;
         @(negedge clk_i);
         n++;
      end
      imem_ack_i = 1'b0;
      check("retire_seen", retire_o, 1);
      check("retire_pc", retire_pc_o, mpc);
      model_exec(ins, mul);
      exp_lat = mul ? 3 + XLEN : 3;
      check("retire_latency", n, exp_lat);
      start_i = keep_start;
      @(negedge clk_i);
      check("retire_pulse", retire_o, 0);
      dbg_addr_i = ins[11:7];
      #1;
      check("dbg_rd", dbg_data_o, mread(int'(ins[11:7])));
      ra         = 5'($urandom);
      dbg_addr_i = ra;
      #1;
      check("dbg_rand", dbg_data_o, mread(int'(ra)));
      if (!keep_start) begin
         check("idle_busy", busy_o, 0);
         check("idle_req", imem_req_o, 0);
         @(negedge clk_i);
         check("idle_stay", busy_o, 0);
         start_i = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      rst_i        = 1'b1;
      start_i      = 1'b0;
      imem_ack_i   = 1'b0;
      imem_instr_i = '0;
      dbg_addr_i   = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      mpc = PC_RESET;
      #2 rst_i = 1'b0;
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_addr", imem_addr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_retire", retire_o, 0);
      check("rst_retire_pc", retire_pc_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("idle_no_start", busy_o, 0);
      start_i = 1'b1;

      run_instr(32'h00500093, 0, 1'b1);
      dbg_addr_i = 5'd1;
      #1 check("x1_addi", dbg_data_o, 32'h5);
      run_instr(32'h40100133, 0, 1'b1);
      dbg_addr_i = 5'd2;
      #1 check("x2_sub", dbg_data_o, 32'hFFFF_FFFB);
      run_instr(32'h00700013, 0, 1'b1);
      dbg_addr_i = 5'd0;
      #1 check("x0_zero", dbg_data_o, 0);
      run_instr(32'h00000013, 3, 1'b1);
      run_instr(32'h022081B3, 1, 1'b1);
      dbg_addr_i = 5'd3;
`ifdef MULTI_CYCLE_MUL_EN
      #1 check("x3_mul", dbg_data_o, 32'hFFFF_FFE7);
`else
      #1 check("x3_mul", dbg_data_o, 32'h0);
`endif

      for (int k = 0; k < 150; k++) begin
         run_instr(gen_instr(), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4)),
                   $urandom_range(0, 5) != 0);
      end

      // Reset while a fetch is pending.
      start_i = 1'b1;
      n = 0;
      while (!imem_req_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      check("pre_rst_req", imem_req_o, 1);
      rst_i = 1'b0;
      #1;
      check("midrst_req", imem_req_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_retire", retire_o, 0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr_i = 5'(i);
         #1 check("midrst_dbg", dbg_data_o, 0);
         mreg[i] = '0;
      end
      mpc = PC_RESET;
      @(negedge clk_i);
      rst_i = 1'b1;
      run_instr(32'h00900113, 0, 1'b1);
      dbg_addr_i = 5'd2;
      #1 check("post_rst_addi", dbg_data_o, 32'h9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
